deal_scheduler: RTL and testbench

Sequences the shared card source (deck/RNG) among the three hands: Player 1, Player 2 and Dealer. It runs the opening deal and serves single-card draw requests issued by fsm during its DRAW_P1, DRAW_P2 and DRAW_D states. It owns the hand registers p1/p2/d high/low consumed by fsm, playerAI and display, and drives cardsUpdated back to fsm.

---
 rtl/blackjack_pkg.sv | 31 +++
 rtl/deal_scheduler_if.sv | 10 +
 rtl/deal_scheduler_hand_accum.sv | 24 ++
 rtl/deal_scheduler.sv | 110 +++++++++++
 tb/tb_deal_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/blackjack_pkg.sv
// Blackjack types and constants shared by the fsm, playerAI, display and deal_scheduler.
package blackjack_pkg;
  localparam int HAND_W = 5;
  localparam int VAL_W  = 4;

  localparam logic [VAL_W-1:0] ACE      = VAL_W'(1);
  localparam logic [VAL_W-1:0] ACE_HIGH = VAL_W'(11);
  localparam logic [VAL_W-1:0] FACE_VAL = VAL_W'(10);
  localparam logic [VAL_W-1:0] KING     = VAL_W'(13);

  typedef struct packed {
    logic [HAND_W-1:0] high;
    logic [HAND_W-1:0] low;   // 0 = no ace counted as 1
  } hand_t;

  typedef enum logic [1:0] {IDLE, CLEAR, REQ} deal_state_t;
  typedef enum logic [1:0] {P1, P2, D} player_e;
  typedef enum logic {DRAW, DEAL} deal_mode_e;

  // Widen by one bit so the carry shows the overflow, then clamp to the hand maximum.
  function automatic logic [HAND_W-1:0] satAdd(input logic [HAND_W-1:0] a,
                                               input logic [VAL_W-1:0] b);
    logic [HAND_W:0] s;
    s = {1'b0, a} + {{(HAND_W+1-VAL_W){1'b0}}, b};
    return s[HAND_W] ? {HAND_W{1'b1}} : s[HAND_W-1:0];
  endfunction

  function automatic logic legalRank(input logic [VAL_W-1:0] r);
    return (r >= ACE) && (r <= KING);
  endfunction
endpackage

// File: rtl/deal_scheduler_if.sv
// Card source handshake: the scheduler requests, the deck/RNG answers with a rank.
interface deal_scheduler_if;
  import blackjack_pkg::*;
  logic             card_req;
  logic             card_valid;
  logic [VAL_W-1:0] card_value;

  modport master (output card_req, input card_valid, input card_value);
  modport slave  (input card_req, output card_valid, output card_value);
endinterface

// File: rtl/deal_scheduler_hand_accum.sv
// Next hand value for one card: face cards count 10, first ace opens the low (soft) sum.
module hand_accum
  import blackjack_pkg::*;
(
  input  hand_t            cur,
  input  logic [VAL_W-1:0] rank,
  output hand_t            nxt
);
  logic [VAL_W-1:0] v;

  always_comb begin
    v   = (rank >= FACE_VAL) ? FACE_VAL : rank;
    nxt = cur;
    if (cur.low != '0) begin
      nxt.high = satAdd(cur.high, v);
      nxt.low  = satAdd(cur.low, v);
    end else if (rank == ACE) begin
      nxt.low  = satAdd(cur.high, ACE);
      nxt.high = satAdd(cur.high, ACE_HIGH);
    end else begin
      nxt.high = satAdd(cur.high, v);
    end
  end
endmodule

// File: rtl/deal_scheduler.sv
// Shares the card source between P1, P2 and Dealer: opening deal plus single draws.
module deal_scheduler
  import blackjack_pkg::*;
#(
  parameter int DEAL_CARDS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_deal,
  input  logic [2:0]            draw_req,
  deal_scheduler_if.master      cardBus,
  output logic [HAND_W-1:0]     p1_high,
  output logic [HAND_W-1:0]     p1_low,
  output logic [HAND_W-1:0]     p2_high,
  output logic [HAND_W-1:0]     p2_low,
  output logic [HAND_W-1:0]     d_high,
  output logic [HAND_W-1:0]     d_low,
  output logic                  cardsUpdated,
  output logic                  deal_done
);
  localparam int DEAL_TOTAL = 3 * DEAL_CARDS;
  localparam int IDX_W      = (DEAL_TOTAL > 1) ? $clog2(DEAL_TOTAL) : 1;

  deal_state_t      state, stateNxt;
  deal_mode_e       mode;
  player_e          target;
  logic [IDX_W-1:0] dealIdx;
  hand_t [2:0]      hands;
  hand_t            nxtHand;
  logic             cardOk, lastDeal, cardReq;

  assign cardOk   = (state == REQ) && cardBus.card_valid && legalRank(cardBus.card_value);
  assign lastDeal = (dealIdx == IDX_W'(DEAL_TOTAL - 1));

  hand_accum u_accum (
    .cur  (hands[target]),
    .rank (cardBus.card_value),
    .nxt  (nxtHand)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    cardReq  = 1'b0;
    unique case (state)
      IDLE:    if (start_deal) stateNxt = CLEAR;
               else if (draw_req != 3'b000) stateNxt = REQ;
      CLEAR:   stateNxt = REQ;
      REQ: begin
        cardReq = 1'b1;
        if (cardOk && (mode == DRAW || lastDeal)) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign cardBus.card_req = cardReq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hands        <= '0;
      target       <= P1;
      mode         <= DRAW;
      dealIdx      <= '0;
      cardsUpdated <= 1'b1;
      deal_done    <= 1'b0;
    end else begin
      cardsUpdated <= (stateNxt == IDLE);
      deal_done    <= cardOk && (mode == DEAL) && lastDeal;
      unique case (state)
        IDLE: if (!start_deal && draw_req != 3'b000) begin
          mode <= DRAW;
          if (draw_req[0])      target <= P1;
          else if (draw_req[1]) target <= P2;
          else                  target <= D;
        end
        CLEAR: begin
          hands   <= '0;
          dealIdx <= '0;
          target  <= P1;
          mode    <= DEAL;
        end
        REQ: if (cardOk) begin
          hands[target] <= nxtHand;
          // Deal rotates P1 -> P2 -> D without leaving REQ.
          if (mode == DEAL && !lastDeal) begin
            dealIdx <= dealIdx + 1'b1;
            unique case (target)
              P1:      target <= P2;
              P2:      target <= D;
              default: target <= P1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign p1_high = hands[P1].high;
  assign p1_low  = hands[P1].low;
  assign p2_high = hands[P2].high;
  assign p2_low  = hands[P2].low;
  assign d_high  = hands[D].high;
  assign d_low   = hands[D].low;
endmodule

// File: tb/tb_deal_scheduler.sv
// Bench for deal_scheduler: directed scenarios with literal hand values, then random traffic vs a queue model.
module tb_deal_scheduler;
  import blackjack_pkg::*;

  localparam int NDEAL = 2;

  logic clk = 1'b0;
  logic reset, start_deal;
  logic [2:0] draw_req;
  logic [HAND_W-1:0] p1_high, p1_low, p2_high, p2_low, d_high, d_low;
  logic cardsUpdated, deal_done;

  deal_scheduler_if cbus();

  deal_scheduler #(.DEAL_CARDS(NDEAL)) dut (
    .clk(clk), .reset(reset), .start_deal(start_deal), .draw_req(draw_req),
    .cardBus(cbus),
    .p1_high(p1_high), .p1_low(p1_low), .p2_high(p2_high), .p2_low(p2_low),
    .d_high(d_high), .d_low(d_low),
    .cardsUpdated(cardsUpdated), .deal_done(deal_done)
  );

  always #5 clk = ~clk;

  int nVec = 0, nErr = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of hands still owed a card; an empty queue means idle.
  int  mH[3], mL[3];
  bit  mReq = 0, mUpd = 1, mDone = 0, mClear = 0, mDeal = 0;
  int  q[$];

  function automatic int sat(input int x);
    return (x > 31) ? 31 : x;
  endfunction

  function automatic void addCard(input int p, input int r);
    int v;
    v = (r >= 10) ? 10 : r;
    if (mL[p] != 0) begin
      mH[p] = sat(mH[p] + v); mL[p] = sat(mL[p] + v);
    end else if (r == 1) begin
      mL[p] = sat(mH[p] + 1); mH[p] = sat(mH[p] + 11);
    end else mH[p] = sat(mH[p] + v);
  endfunction

  initial for (int i = 0; i < 3; i++) begin mH[i] = 0; mL[i] = 0; end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin mH[i] = 0; mL[i] = 0; end
      q.delete(); mClear = 0; mDeal = 0; mReq = 0; mUpd = 1; mDone = 0;
    end else begin
      mDone = 0;
      if (mClear) begin
        for (int i = 0; i < 3; i++) begin mH[i] = 0; mL[i] = 0; end
        for (int k = 0; k < NDEAL; k++) begin q.push_back(0); q.push_back(1); q.push_back(2); end
        mClear = 0; mDeal = 1;
      end else if (q.size() != 0) begin
        if (cbus.card_valid && cbus.card_value >= 1 && cbus.card_value <= 13) begin
          addCard(q[0], int'(cbus.card_value));
          void'(q.pop_front());
          if (q.size() == 0 && mDeal) mDone = 1;
        end
      end else if (start_deal) mClear = 1;
      else if (draw_req != 3'b000) begin
        q.push_back(draw_req[0] ? 0 : (draw_req[1] ? 1 : 2));
        mDeal = 0;
      end
      mReq = (q.size() != 0);
      mUpd = !mClear && (q.size() == 0);
    end
  end

  logic [HAND_W-1:0] dH[3], dL[3];
  assign dH[0] = p1_high; assign dL[0] = p1_low;
  assign dH[1] = p2_high; assign dL[1] = p2_low;
  assign dH[2] = d_high;  assign dL[2] = d_low;

  always @(negedge clk) begin
    chk("card_req", cbus.card_req, mReq);
    chk("cardsUpdated", cardsUpdated, mUpd);
    chk("deal_done", deal_done, mDone);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("high[%0d]", i), dH[i], mH[i]);
      chk($sformatf("low[%0d]", i), dL[i], mL[i]);
    end
  end

  // Card source: directed queue served only while requested, or free-running random.
  int srcQ[$];
  bit srcRand = 0;
  initial begin
    cbus.card_valid = 1'b0; cbus.card_value = '0;
    forever begin
      @(posedge clk); #2;
      if (srcRand) begin
        cbus.card_valid = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 7) == 0) begin
          int t;
          t = $urandom_range(0, 2);
          cbus.card_value = (t == 0) ? 4'd0 : VAL_W'(13 + t);
        end else cbus.card_value = VAL_W'($urandom_range(1, 13));
      end else if (cbus.card_req && srcQ.size() != 0) begin
        cbus.card_valid = 1'b1;
        cbus.card_value = VAL_W'(srcQ.pop_front());
      end else cbus.card_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic waitUpd(input string nm);
    int n;
    n = 0;
    tick();
    while (!cardsUpdated && n < 30) begin tick(); n++; end
    chk({nm, "_timeout"}, cardsUpdated, 1);
  endtask

  task automatic runDeal(input string nm);
    int n, reqs;
    n = 0; reqs = 0;
    start_deal = 1'b1; tick(); start_deal = 1'b0; draw_req = 3'b000;
    while (!deal_done && n < 40) begin
      tick(); n++;
      if (cbus.card_req) reqs++;
    end
    chk({nm, "_done"}, deal_done, 1);
    chk({nm, "_reqcycles"}, reqs, 3 * NDEAL);
    tick();
    chk({nm, "_donepulse"}, deal_done, 0);
  endtask

  initial begin
    reset = 1'b0; start_deal = 1'b0; draw_req = 3'b000;
    #1 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_req", cbus.card_req, 0);
    chk("rst_upd", cardsUpdated, 1);

    // Reset lands while a card is being presented in REQ.
    srcQ.push_back(9);
    draw_req = 3'b001; tick(); draw_req = 3'b000;
    #1 reset = 1'b1;
    tick(); reset = 1'b0; tick();
    chk("midrst_p1h", p1_high, 0);
    chk("midrst_req", cbus.card_req, 0);
    chk("midrst_upd", cardsUpdated, 1);

    srcQ = {5, 7, 10, 1, 13, 6};
    runDeal("deal1");
    chk("deal1_p1h", p1_high, 16); chk("deal1_p1l", p1_low, 6);
    chk("deal1_p2h", p2_high, 17); chk("deal1_p2l", p2_low, 0);
    chk("deal1_dh", d_high, 16);   chk("deal1_dl", d_low, 0);

    srcQ = {10, 2, 3, 6, 4, 5};
    runDeal("deal2");
    chk("deal2_p1h", p1_high, 16); chk("deal2_p1l", p1_low, 0);

    srcQ = {1};
    draw_req = 3'b001; tick(); draw_req = 3'b000; waitUpd("ace");
    chk("ace_p1h", p1_high, 27); chk("ace_p1l", p1_low, 17);
    srcQ = {12};
    draw_req = 3'b001; tick(); draw_req = 3'b000; waitUpd("sat");
    chk("sat_p1h", p1_high, 31); chk("sat_p1l", p1_low, 27);

    // Multi-hot held: p1 wins, and a held request restarts a p1 draw.
    srcQ = {4, 2};
    draw_req = 3'b111; tick(); tick();
    chk("multi_p1l", p1_low, 31); chk("multi_p2h", p2_high, 6); chk("multi_dh", d_high, 8);
    chk("multi_upd", cardsUpdated, 1);
    tick();
    chk("multi_again", cbus.card_req, 1);
    draw_req = 3'b000; waitUpd("multi2");

    srcQ = {0, 15, 9};
    draw_req = 3'b010; tick(); draw_req = 3'b000;
    tick(); chk("bad0_req", cbus.card_req, 1);
    tick(); chk("bad15_req", cbus.card_req, 1); chk("bad15_p2h", p2_high, 6);
    tick(); chk("good9_p2h", p2_high, 15); chk("good9_upd", cardsUpdated, 1);

    srcQ = {2, 3, 4, 5, 6, 7};
    draw_req = 3'b010;
    runDeal("deal3");
    chk("deal3_p1h", p1_high, 7); chk("deal3_p2h", p2_high, 9); chk("deal3_dh", d_high, 11);

    srcRand = 1;
    for (int i = 0; i < 800; i++) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      start_deal = ($urandom_range(0, 11) == 0);
      draw_req = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    end
    reset = 1'b0; start_deal = 1'b0; draw_req = 3'b000; srcRand = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
